// File: rtl/state_multi_ref_event_logger.sv
// Debug-state mismatch logger: latest/sticky and first-fault mismatch vectors plus a
// show-ahead FIFO of timestamped mismatch events for a debug reader to drain.
module state_multi_ref_event_logger #(
  parameter int unsigned BITS    = 8,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TS_BITS = 16,
  parameter int unsigned STICKY  = 0
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iClear,
  input  logic                       iEnable,
  input  logic [BITS-1:0]            iRef,
  input  logic [BITS-1:0]            iDbgSt,
  input  logic                       iRdEn,
  output logic [BITS-1:0]            oChange,
  output logic [BITS-1:0]            oFirst,
  output logic                       oFirstValid,
  output logic                       oEvtValid,
  output logic [BITS-1:0]            oEvtDiff,
  output logic [TS_BITS-1:0]         oEvtTs,
  output logic [$clog2(DEPTH+1)-1:0] oCount,
  output logic                       oOverflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = TS_BITS + BITS;

  logic [TS_BITS-1:0] r_ts;
  logic [BITS-1:0]    r_prev;
  logic [BITS-1:0]    r_change;
  logic [BITS-1:0]    r_first;
  logic               r_first_valid;
  logic [EW-1:0]      r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;

  logic               w_rst;
  logic [BITS-1:0]    w_diff;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_wr;
  logic [BITS-1:0]    w_change_d;
  logic [CW-1:0]      w_count_d;
  logic [EW-1:0]      w_head;

  assign w_rst  = iRst | iClear;
  assign w_diff = iDbgSt ^ iRef;
  assign w_full = (r_count == CW'(DEPTH));
  assign w_pop  = iRdEn & (r_count != '0);
  // A persistent mismatch is logged once; it re-logs only after the vector changes.
  assign w_push = iEnable & (w_diff != '0) & (w_diff != r_prev);
  // Simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign w_wr   = w_push & (~w_full | w_pop);

  always_comb begin
    w_change_d = r_change;
    if (STICKY != 0) begin
      w_change_d = r_change | w_diff;
    end else if (w_diff != '0) begin
      w_change_d = w_diff;
    end
  end

  always_comb begin
    w_count_d = r_count;
    unique case ({w_wr, w_pop})
      2'b10:   w_count_d = r_count + CW'(1);
      2'b01:   w_count_d = r_count - CW'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (w_rst) begin
      r_ts          <= '0;
      r_prev        <= '0;
      r_change      <= '0;
      r_first       <= '0;
      r_first_valid <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_BITS'(1);
      if (iEnable) begin
        r_prev   <= w_diff;
        r_change <= w_change_d;
        if ((w_diff != '0) && !r_first_valid) begin
          r_first       <= w_diff;
          r_first_valid <= 1'b1;
        end
      end
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= w_count_d;
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge iClk) begin
    if (w_wr && !w_rst) begin
      r_mem[r_wr_ptr] <= {r_ts, w_diff};
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign oChange     = r_change;
  assign oFirst      = r_first;
  assign oFirstValid = r_first_valid;
  assign oEvtValid   = (r_count != '0);
  assign oEvtDiff    = oEvtValid ? w_head[BITS-1:0] : '0;
  assign oEvtTs      = oEvtValid ? w_head[EW-1:BITS] : '0;
  assign oCount      = r_count;
  assign oOverflow   = r_overflow;

endmodule

// File: tb/tb_state_multi_ref_event_logger.sv
// Directed bench for state_multi_ref_event_logger (BITS=4, DEPTH=4, TS_BITS=8); a second
// instance with STICKY=1 shares the stimulus.
module tb_state_multi_ref_event_logger;

  logic       iClk = 1'b0;
  logic       iRst, iClear, iEnable, iRdEn;
  logic [3:0] iRef, iDbgSt;

  logic [3:0] oChange, oFirst, oEvtDiff;
  logic       oFirstValid, oEvtValid, oOverflow;
  logic [7:0] oEvtTs;
  logic [2:0] oCount;

  logic [3:0] s_change, s_first, s_evt_diff;
  logic       s_first_valid, s_evt_valid, s_overflow;
  logic [7:0] s_evt_ts;
  logic [2:0] s_count;

  int checks   = 0;
  int failures = 0;

  always #5 iClk = ~iClk;

  state_multi_ref_event_logger #(
    .BITS(4), .DEPTH(4), .TS_BITS(8), .STICKY(0)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iClear(iClear), .iEnable(iEnable), .iRef(iRef),
    .iDbgSt(iDbgSt), .iRdEn(iRdEn), .oChange(oChange), .oFirst(oFirst),
    .oFirstValid(oFirstValid), .oEvtValid(oEvtValid), .oEvtDiff(oEvtDiff),
    .oEvtTs(oEvtTs), .oCount(oCount), .oOverflow(oOverflow)
  );

  state_multi_ref_event_logger #(
    .BITS(4), .DEPTH(4), .TS_BITS(8), .STICKY(1)
  ) dut_s (
    .iClk(iClk), .iRst(iRst), .iClear(iClear), .iEnable(iEnable), .iRef(iRef),
    .iDbgSt(iDbgSt), .iRdEn(iRdEn), .oChange(s_change), .oFirst(s_first),
    .oFirstValid(s_first_valid), .oEvtValid(s_evt_valid), .oEvtDiff(s_evt_diff),
    .oEvtTs(s_evt_ts), .oCount(s_count), .oOverflow(s_overflow)
  );

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [7:0] ts, input logic [3:0] diff);
    check({tag, " valid"}, 32'(oEvtValid), 32'd1);
    check({tag, " ts"}, 32'(oEvtTs), 32'(ts));
    check({tag, " diff"}, 32'(oEvtDiff), 32'(diff));
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    iRst = 1'b0; iClear = 1'b0; iEnable = 1'b1; iRdEn = 1'b0;
    iRef = 4'hA; iDbgSt = 4'hA;

    // 1: reset then matching state for 10 cycles
    do_reset();
    check("rst change", 32'(oChange), 32'd0);
    check("rst count", 32'(oCount), 32'd0);
    tick(10);
    check("t1 change", 32'(oChange), 32'd0);
    check("t1 first_valid", 32'(oFirstValid), 32'd0);
    check("t1 evt_valid", 32'(oEvtValid), 32'd0);
    check("t1 count", 32'(oCount), 32'd0);
    check("t1 evt_diff", 32'(oEvtDiff), 32'd0);

    // 2/3: mismatch B at ts=5 for 3 cycles, A for ts 8-9, 2 at ts=10
    do_reset();
    tick(5);
    iDbgSt = 4'hB;
    tick();
    check("t2 count1", 32'(oCount), 32'd1);
    check_head("t2 head1", 8'd5, 4'h1);
    tick(2);
    iDbgSt = 4'hA;
    tick(2);
    iDbgSt = 4'h2;
    tick();
    iDbgSt = 4'hA;
    check("t2 count2", 32'(oCount), 32'd2);
    check("t2 first", 32'(oFirst), 32'h1);
    check("t2 first_valid", 32'(oFirstValid), 32'd1);
    check("t2 change", 32'(oChange), 32'h8);
    check("t3 sticky change", 32'(s_change), 32'h9);
    check_head("t2 read0", 8'd5, 4'h1);
    iRdEn = 1'b1;
    tick();
    check_head("t2 read1", 8'd10, 4'h8);
    tick();
    iRdEn = 1'b0;
    check("t2 drained valid", 32'(oEvtValid), 32'd0);
    check("t2 drained ts", 32'(oEvtTs), 32'd0);
    check("t2 overflow", 32'(oOverflow), 32'd0);

    // 4: six distinct mismatches, no reads
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      iDbgSt = 4'hA ^ 4'(k);
      tick();
    end
    iDbgSt = 4'hA;
    check("t4 count", 32'(oCount), 32'd4);
    check("t4 overflow", 32'(oOverflow), 32'd1);
    iRdEn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("t4 read%0d", k), 8'(k), 4'(k + 1));
      tick();
    end
    iRdEn = 1'b0;
    check("t4 empty", 32'(oEvtValid), 32'd0);

    // 5: push and pop together while full
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      iDbgSt = 4'hA ^ 4'(k);
      tick();
    end
    check("t5 full", 32'(oCount), 32'd4);
    iDbgSt = 4'hA ^ 4'h5;
    iRdEn = 1'b1;
    tick();
    iDbgSt = 4'hA;
    check("t5 count", 32'(oCount), 32'd4);
    check("t5 overflow", 32'(oOverflow), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("t5 read%0d", k), 8'(k + 1), 4'(k + 2));
      tick();
    end
    iRdEn = 1'b0;
    check("t5 empty", 32'(oCount), 32'd0);

    // 6: clear coincident with a push
    iDbgSt = 4'hA ^ 4'h7;
    tick();
    check("t6 pre count", 32'(oCount), 32'd1);
    iDbgSt = 4'hA ^ 4'h3;
    iClear = 1'b1;
    tick();
    iClear = 1'b0;
    check("t6 count", 32'(oCount), 32'd0);
    check("t6 change", 32'(oChange), 32'd0);
    check("t6 first", 32'(oFirst), 32'd0);
    check("t6 first_valid", 32'(oFirstValid), 32'd0);
    check("t6 evt_valid", 32'(oEvtValid), 32'd0);
    check("t6 sticky change", 32'(s_change), 32'd0);
    tick();
    check_head("t6 ts restart", 8'd0, 4'h3);

    // 7: disabled compare, reads still pop
    iEnable = 1'b0;
    iDbgSt = 4'hA ^ 4'h6;
    iRdEn = 1'b1;
    tick();
    iRdEn = 1'b0;
    check("t7 popped", 32'(oCount), 32'd0);
    tick(2);
    check("t7 no push", 32'(oCount), 32'd0);
    check("t7 change hold", 32'(oChange), 32'h3);
    check("t7 first hold", 32'(oFirst), 32'h3);
    iEnable = 1'b1;
    iDbgSt = 4'hA;

    // 8: timestamp wrap
    do_reset();
    tick(255);
    iDbgSt = 4'hA ^ 4'h1;
    tick();
    iDbgSt = 4'hA ^ 4'h2;
    tick();
    iDbgSt = 4'hA;
    check("t8 count", 32'(oCount), 32'd2);
    check_head("t8 head0", 8'hFF, 4'h1);
    iRdEn = 1'b1;
    tick();
    iRdEn = 1'b0;
    check_head("t8 head1", 8'h00, 4'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
